fp16b_div_iter: RTL and testbench
=================================

// Module: fp16b_div_iter
// PURPOSE
//  Iterative bfloat16 (FP16B) divider, ret_0 = arg_0 / arg_1: the inverse operation of the FP16B multiplier.
//  Sits in the same FP library as the multiplier, for datapaths that need quotients.
//  Restoring division of the hidden-bit mantissas, BITS_PER_CYCLE quotient bits per clock.
//  Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  BITS_PER_CYCLE  1  quotient bits per DIV cycle; legal 1, 2, 5; N = 10/BITS_PER_CYCLE DIV cycles
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  arg_0      in   16  dividend {s,e[7:0],f[6:0]}
//  arg_1      in   16  divisor
//  arg_valid  in   1   operands valid
//  arg_ready  out  1   high only in IDLE; accept = arg_valid & arg_ready at a rising edge
//  ret_0      out  16  quotient, held stable while ret_valid=1
//  ret_valid  out  1   result available
//  ret_ready  in   1   consumer takes result when ret_valid & ret_ready at a rising edge
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ret_0=0, ret_valid=0, arg_ready=1, internal registers cleared.
//  Reset mid-DIV or mid-DONE aborts the operation; no result is produced.
//  FSM: IDLE -(accept, special)-> DONE; IDLE -(accept, normal)-> DIV; DIV -(N-th edge)-> DONE;
//       DONE -(ret_ready)-> IDLE. No accept in DONE. Min. issue interval is N+2 cycles.
//  Latency: normal operands: ret_valid visible after the N-th edge following the accept edge.
//           Special operands: ret_valid visible right after the accept edge.
//  Sign: s = s0 ^ s1 in every case, including NaN.
//  Special cases, in priority order (e==0 is zero; denormals flush to zero):
//   e0==255 & e1==255, or e0==0 & e1==0    -> {s,8'hFF,7'h40} (NaN)
//   e0==255 or e1==0                       -> {s,8'hFF,7'h00} (inf)
//   e1==255 or e0==0                       -> {s,8'h00,7'h00} (zero)
//  Normal: ff0={1,f0}, ff1={1,f1}; q = ({ff0,9'b0}) / ff1, 10-bit q, value in (256,1020], remainder r.
//   DIV shifts in BITS_PER_CYCLE bits/cycle: trial subtract, then restore.
//   q[9]=1: frac=q[8:2], guard=q[1], sticky=q[0]|(r!=0)
//   q[9]=0: frac=q[7:1], guard=q[0], sticky=(r!=0)
//   e10 (10-bit signed) = {2'b0,e0} - e1 + 126 + q[9]
//   e10[9]=1 or e10==0 -> underflow -> {s,0,0}
//   e10>=255 -> overflow -> {s,8'hFF,0}
//   otherwise {s,e10[7:0],frac}
//  Normalisation, rounding and exponent checks occur on the N-th DIV edge, then ret_0 is registered.
// CONFIGURATION
//  FP16B_DIV_ROUND_EN defined: round-to-nearest-even.
//   Increment frac if guard & (sticky | frac[0]).
//   Carry out of frac -> frac=0, e10+1; overflow check applies after the increment.
//  Not defined: truncation; guard and sticky ignored (these registers may be optimised away).
//  Latency and handshake are identical in both builds.
// TESTING
//  0x3FC0 / 0x3F80, BITS_PER_CYCLE=1 -> ret_0=0x3FC0; ret_valid 10 cycles after accept.
//  0x3F80 / 0x4040 -> 0x3EAA truncating; 0x3EAB with FP16B_DIV_ROUND_EN.
//  Special inputs, each with 1-cycle latency:
//   0x3F80 / 0x0000 -> 0x7F80; 0xBF80 / 0x0000 -> 0xFF80; 0x0000 / 0x0000 -> 0x7FC0.
//  Range limits: 0x7F00 / 0x3E80 -> 0x7F80 (overflow); 0x0080 / 0x4000 -> 0x0000 (underflow).
//  Handshake:
//   Hold ret_ready=0 for 5 cycles -> ret_0/ret_valid stable and arg_ready=0.
//   Set ret_ready=1 -> IDLE on the next edge; arg_valid held high is accepted there.
//  Drop rst during DIV:
//   ret_valid=0 and arg_ready=1 immediately.
//   A new 0x4040 / 0x4000 after release -> 0x3FC0.
//  Repeat the first two cases with BITS_PER_CYCLE=2 and 5 -> same results, latency 5 and 2.

Source files
------------

// File: rtl/fp16b_div_iter.sv
// -----------------------------------------------------------------------------
// fp16b_div_iter
//   Iterative bfloat16 divider: ret_0 = arg_0 / arg_1.
//   The hidden-bit mantissas go through a restoring division that produces
//   BITS_PER_CYCLE quotient bits per clock. The 10-bit quotient therefore takes
//   N = 10 / BITS_PER_CYCLE clocks. Only one operation is in flight at a time.
//   Special operands (zero, inf, NaN) skip the division and finish one clock
//   after they are accepted.
//
// Parameters
//   BITS_PER_CYCLE  quotient bits per DIV cycle (1, 2 or 5)
//
// Configuration macro
//   FP16B_DIV_ROUND_EN  defined: round-to-nearest-even on the quotient fraction.
//                       undefined: the fraction is truncated.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   arg_0      in   dividend {s, e[7:0], f[6:0]}
//   arg_1      in   divisor
//   arg_valid  in   operands valid
//   arg_ready  out  high only in IDLE
//   ret_0      out  quotient, held stable while ret_valid is high
//   ret_valid  out  result available
//   ret_ready  in   consumer takes the result when ret_valid & ret_ready
// -----------------------------------------------------------------------------
module fp16b_div_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] arg_0,
    input  logic [15:0] arg_1,
    input  logic        arg_valid,
    output logic        arg_ready,
    output logic [15:0] ret_0,
    output logic        ret_valid,
    input  logic        ret_ready
);

    localparam int         N    = 10 / BITS_PER_CYCLE;
    localparam logic [3:0] LAST = 4'(N - 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t state, state_nxt;

    logic [3:0]        cnt;
    logic [9:0]        quo;
    logic [8:0]        rem;
    logic [7:0]        dsr;
    logic              sign;
    logic signed [9:0] exp_base;

    logic              accept;
    logic              s_in;
    logic [7:0]        e0, e1;
    logic              special;
    logic [15:0]       special_res;
    logic [9:0]        quo_nxt;
    logic [8:0]        rem_nxt;
    logic [15:0]       div_res;

    assign s_in   = arg_0[15] ^ arg_1[15];
    assign e0     = arg_0[14:7];
    assign e1     = arg_1[14:7];
    assign accept = arg_valid & arg_ready;

`ifdef FP16B_DIV_ROUND_EN
    // Returns {e10, frac}; a carry out of the fraction bumps the exponent and
    // leaves the fraction at zero.
    function automatic logic [16:0] round_ne(input logic signed [9:0] e10,
                                             input logic [6:0]        frac,
                                             input logic              guard,
                                             input logic              sticky);
        logic [7:0]        sum;
        logic signed [9:0] e_out;
        sum   = {1'b0, frac};
        e_out = e10;
        if (guard && (sticky || frac[0]))
            sum = sum + 8'd1;
        if (sum[7])
            e_out = e10 + 10'sd1;
        return {e_out, sum[6:0]};
    endfunction
`endif

    // Flush to signed zero on underflow, saturate to signed inf on overflow.
    function automatic logic [15:0] pack_sat(input logic              s,
                                             input logic              under,
                                             input logic signed [9:0] e10,
                                             input logic [6:0]        frac);
        if (under)
            return {s, 15'h0000};
        else if (e10 >= 10'sd255)
            return {s, 8'hFF, 7'h00};
        else
            return {s, e10[7:0], frac};
    endfunction

    // Special operands in priority order; e==0 counts as zero (no denormals).
    always_comb begin
        special     = 1'b1;
        special_res = 16'h0000;
        if ((e0 == 8'hFF && e1 == 8'hFF) || (e0 == 8'h00 && e1 == 8'h00))
            special_res = {s_in, 8'hFF, 7'h40};
        else if (e0 == 8'hFF || e1 == 8'h00)
            special_res = {s_in, 8'hFF, 7'h00};
        else if (e1 == 8'hFF || e0 == 8'h00)
            special_res = {s_in, 15'h0000};
        else
            special = 1'b0;
    end

    // Restoring division steps. rem holds the partial remainder to compare
    // against the divisor; it always stays below 2*dsr, so 9 bits suffice and
    // the left shift after each step never drops a set bit.
    always_comb begin
        logic [8:0] r;
        logic [9:0] q;
        logic [9:0] diff;
        r    = rem;
        q    = quo;
        diff = 10'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            diff = {1'b0, r} - {2'b00, dsr};
            q    = {q[8:0], ~diff[9]};
            if (!diff[9])
                r = diff[8:0];
            r = {r[7:0], 1'b0};
        end
        quo_nxt = q;
        rem_nxt = r;
    end

    // Normalise, round and range-check the quotient finishing this cycle.
    always_comb begin
        logic [6:0]        frac;
        logic signed [9:0] e10;
        logic              under;
`ifdef FP16B_DIV_ROUND_EN
        logic              guard;
        logic              sticky;
        logic [16:0]       rounded;
`endif
        frac  = quo_nxt[9] ? quo_nxt[8:2] : quo_nxt[7:1];
        e10   = exp_base + $signed({9'b0, quo_nxt[9]});
        under = e10[9] || (e10 == 10'sd0);
`ifdef FP16B_DIV_ROUND_EN
        guard   = quo_nxt[9] ? quo_nxt[1] : quo_nxt[0];
        sticky  = (quo_nxt[9] & quo_nxt[0]) | (rem_nxt != 9'd0);
        rounded = round_ne(e10, frac, guard, sticky);
        e10     = $signed(rounded[16:7]);
        frac    = rounded[6:0];
`endif
        div_res = pack_sat(sign, under, e10, frac);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : DIV;
            DIV:  if (cnt == LAST) state_nxt = DONE;
            DONE: if (ret_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        arg_ready = (state == IDLE);
        ret_valid = (state == DONE);
    end

    // Datapath registers: operand capture, division steps, result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 4'd0;
            quo      <= 10'd0;
            rem      <= 9'd0;
            dsr      <= 8'd0;
            sign     <= 1'b0;
            exp_base <= 10'sd0;
            ret_0    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign     <= s_in;
                        dsr      <= {1'b1, arg_1[6:0]};
                        rem      <= {2'b01, arg_0[6:0]};
                        quo      <= 10'd0;
                        cnt      <= 4'd0;
                        exp_base <= $signed({2'b00, e0}) - $signed({2'b00, e1}) + 10'sd126;
                        if (special)
                            ret_0 <= special_res;
                    end
                end
                DIV: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST)
                        ret_0 <= div_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16b_div_iter.sv
`timescale 1ns/1ps
module tb_fp16b_div_iter;

    localparam int NDUT = 3;
    localparam int BPC [NDUT] = '{1, 2, 5};

`ifdef FP16B_DIV_ROUND_EN
    localparam logic [15:0] THIRD_RES = 16'h3EAB;
`else
    localparam logic [15:0] THIRD_RES = 16'h3EAA;
`endif

    typedef struct packed {
        logic [15:0] val;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] arg_0, arg_1;
    logic        arg_valid [NDUT];
    logic        arg_ready [NDUT];
    logic [15:0] ret_0     [NDUT];
    logic        ret_valid [NDUT];
    logic        ret_ready [NDUT];

    exp_t exp_q [NDUT][$];
    int   acc_cyc  [NDUT];
    bit   acc_done [NDUT];
    bit   seen     [NDUT];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rr_random = 1'b0;
    bit   rr_force = 1'b1;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        fp16b_div_iter #(.BITS_PER_CYCLE(BPC[k])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .arg_0     (arg_0),
            .arg_1     (arg_1),
            .arg_valid (arg_valid[k]),
            .arg_ready (arg_ready[k]),
            .ret_0     (ret_0[k]),
            .ret_valid (ret_valid[k]),
            .ret_ready (ret_ready[k])
        );
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut_bpc%0d actual=0x%0h required=0x%0h", name, BPC[k], act, req);
        end
    endtask

    // Reference model: quotient from plain integer division of the scaled
    // mantissas, then the exponent/rounding rules.
    function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
        return (a[14:7] == 8'h00) || (a[14:7] == 8'hFF) || (b[14:7] == 8'h00) || (b[14:7] == 8'hFF);
    endfunction

    function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int e0, e1, ff0, ff1, q, e, frac;
        bit s, under;
`ifdef FP16B_DIV_ROUND_EN
        int r;
        bit g, st;
`endif
        e0 = int'(a[14:7]);
        e1 = int'(b[14:7]);
        s  = a[15] ^ b[15];
        if ((e0 == 255 && e1 == 255) || (e0 == 0 && e1 == 0)) return {s, 8'hFF, 7'h40};
        if (e0 == 255 || e1 == 0) return {s, 8'hFF, 7'h00};
        if (e1 == 255 || e0 == 0) return {s, 15'h0000};
        ff0 = 128 + int'(a[6:0]);
        ff1 = 128 + int'(b[6:0]);
        q   = (ff0 * 512) / ff1;
        if (q >= 512) begin
            frac = (q / 4) % 128;
            e    = e0 - e1 + 127;
        end else begin
            frac = (q / 2) % 128;
            e    = e0 - e1 + 126;
        end
        under = (e <= 0);
`ifdef FP16B_DIV_ROUND_EN
        r  = (ff0 * 512) % ff1;
        g  = (q >= 512) ? ((q / 2) % 2 == 1) : (q % 2 == 1);
        st = ((q >= 512) && (q % 2 == 1)) || (r != 0);
        if (g && (st || (frac % 2 == 1))) begin
            frac++;
            if (frac == 128) begin
                frac = 0;
                e++;
            end
        end
`endif
        if (under) return {s, 15'h0000};
        if (e >= 255) return {s, 8'hFF, 7'h00};
        return {s, 8'(e), 7'(frac)};
    endfunction

    function automatic logic [15:0] rand_op();
        int c;
        logic [7:0] e;
        c = $urandom_range(0, 9);
        if (c == 0)      e = 8'h00;
        else if (c == 1) e = 8'hFF;
        else if (c < 5)  e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    // Accept tracker: samples the handshake at the active edge before the
    // DUT state updates.
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NDUT; k++) begin
            if (rst && arg_valid[k] && arg_ready[k]) begin
                acc_cyc[k]  = cyc;
                acc_done[k] = 1'b1;
            end
        end
    end

    // Monitor: drives ret_ready for the coming edge, then checks outputs.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            ret_ready[k] = rr_random ? 1'($urandom_range(0, 1)) : rr_force;
            if (rst && ret_valid[k]) begin
                check("arg_ready_in_done", k, 32'(arg_ready[k]), 32'd0);
                if (exp_q[k].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result dut_bpc%0d actual=0x%0h required=none", BPC[k], ret_0[k]);
                end else begin
                    if (!seen[k]) begin
                        seen[k] = 1'b1;
                        check("latency", k, 32'(cyc - acc_cyc[k]), 32'(exp_q[k][0].lat));
                    end
                    check("result", k, 32'(ret_0[k]), 32'(exp_q[k][0].val));
                    if (ret_ready[k]) begin
                        void'(exp_q[k].pop_front());
                        seen[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expv, input bit spec);
        bit all_acc;
        exp_t e;
        arg_0 = a;
        arg_1 = b;
        for (int k = 0; k < NDUT; k++) begin
            acc_done[k]  = 1'b0;
            arg_valid[k] = 1'b1;
            e.val = expv;
            e.lat = spec ? 8'd0 : 8'(10 / BPC[k]);
            exp_q[k].push_back(e);
        end
        all_acc = 1'b0;
        for (int t = 0; t < 300 && !all_acc; t++) begin
            @(negedge clk);
            all_acc = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                if (acc_done[k]) arg_valid[k] = 1'b0;
                else all_acc = 1'b0;
            end
        end
        if (!all_acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted a=0x%0h b=0x%0h", a, b);
            for (int k = 0; k < NDUT; k++) arg_valid[k] = 1'b0;
        end
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int t = 0; t < 500 && !empty; t++) begin
            @(negedge clk);
            empty = 1'b1;
            for (int k = 0; k < NDUT; k++)
                if (exp_q[k].size() != 0) empty = 1'b0;
        end
        for (int k = 0; k < NDUT; k++)
            check("drain_pending", k, 32'(exp_q[k].size()), 32'd0);
    endtask

    task automatic reset_mid();
        for (int k = 0; k < NDUT; k++)
            check("busy_before_reset", k, 32'(arg_ready[k]), 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            exp_q[k].delete();
            seen[k]      = 1'b0;
            arg_valid[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("reset_ret_valid", k, 32'(ret_valid[k]), 32'd0);
            check("reset_arg_ready", k, 32'(arg_ready[k]), 32'd1);
            check("reset_ret_0", k, 32'(ret_0[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] a, b;
        rst   = 1'b0;
        arg_0 = 16'h0000;
        arg_1 = 16'h0000;
        for (int k = 0; k < NDUT; k++) begin
            arg_valid[k] = 1'b0;
            ret_ready[k] = 1'b1;
            acc_cyc[k]   = 0;
            acc_done[k]  = 1'b0;
            seen[k]      = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("reset_ret_valid", k, 32'(ret_valid[k]), 32'd0);
            check("reset_arg_ready", k, 32'(arg_ready[k]), 32'd1);
            check("reset_ret_0", k, 32'(ret_0[k]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Directed values
        issue(16'h3FC0, 16'h3F80, 16'h3FC0, 1'b0);
        issue(16'h3F80, 16'h4040, THIRD_RES, 1'b0);
        issue(16'h3F80, 16'h0000, 16'h7F80, 1'b1);
        issue(16'hBF80, 16'h0000, 16'hFF80, 1'b1);
        issue(16'h0000, 16'h0000, 16'h7FC0, 1'b1);
        issue(16'h7F00, 16'h3E80, 16'h7F80, 1'b0);
        issue(16'h0080, 16'h4000, 16'h0000, 1'b0);
        issue(16'h7F80, 16'hFF80, 16'hFFC0, 1'b1);
        issue(16'h4000, 16'h7F80, 16'h0000, 1'b1);
        drain();

        // Back-pressure: result held while ret_ready is low
        rr_force = 1'b0;
        issue(16'h4040, 16'h4000, 16'h3FC0, 1'b0);
        repeat (16) @(negedge clk);
        rr_force = 1'b1;
        issue(16'h3FC0, 16'h3F80, 16'h3FC0, 1'b0);
        drain();

        // Abort in DIV, then a fresh operation
        issue(16'h3F80, 16'h4040, THIRD_RES, 1'b0);
        reset_mid();
        issue(16'h4040, 16'h4000, 16'h3FC0, 1'b0);
        drain();

        // Randomized operands with random consumer back-pressure
        rr_random = 1'b1;
        repeat (150) begin
            a = rand_op();
            b = rand_op();
            issue(a, b, ref_div(a, b), is_special(a, b));
        end
        rr_random = 1'b0;
        rr_force  = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
